instr_loader: RTL and testbench
===============================

Name: instr_loader

Overview:
Loads a program image into the single-cycle MIPS instruction memory from a byte stream. Bytes arrive over a valid/ready interface and are packed into 32-bit instruction words. Each word is written sequentially to imem, and the image is validated with an XOR checksum. The processor is held in reset (cpu_hold) until a complete, checksum-valid image has been written.

Parameters:
ADDR_W, 8, imem word-address width; capacity is 2^ADDR_W words.
BIG_ENDIAN, 1, 1 = first byte of each word goes to bits [31:24]; 0 = first byte goes to bits [7:0].

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
start  input  1  single-cycle pulse; begins a load when in IDLE, DONE or ERROR.
in_valid  input  1  byte-stream valid.
in_data  input  8  byte-stream data.
in_ready  output  1  loader can accept a byte this cycle.
imem_we  output  1  instruction-memory write strobe, one cycle per word.
imem_addr  output  ADDR_W  word address, qualified by imem_we.
imem_wdata  output  32  instruction word, qualified by imem_we.
cpu_hold  output  1  1 = processor held in reset.
done  output  1  level; image loaded and checksum OK.
err  output  1  level; length overflow or checksum mismatch.

Behaviour:
- Reset values: state=IDLE, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, err=0, byte counter=0, word counter=0, checksum=0x00.
- Handshake: a byte is accepted on a rising edge where in_valid & in_ready. in_ready is a registered decode of state: 1 in LEN_HI, LEN_LO, DATA and CHECK; 0 otherwise. in_data is ignored when no transfer occurs.
- Stream format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4*N data bytes, then 1 checksum byte. The checksum byte equals the XOR of all data bytes; length bytes are excluded.
- FSM:
  - IDLE: on start -> LEN_HI; clear counters, checksum, done and err.
  - LEN_HI: on accept, latch N[15:8] -> LEN_LO.
  - LEN_LO: on accept, latch N[7:0] and evaluate the full N:
    - N > 2^ADDR_W -> ERROR.
    - N = 0 -> CHECK.
    - otherwise -> DATA.
  - DATA: each accepted byte is shifted into the word assembler and XORed into checksum.
    - On the 4th byte of a word, the next cycle drives imem_we=1 for exactly one cycle, with imem_addr = word index and imem_wdata = assembled word.
    - Word index starts at 0 and increments after each write.
    - After word N-1 is accepted -> CHECK. The final write pulse occurs in the first CHECK cycle.
  - CHECK: on accept, compare the byte with the running checksum. Match -> DONE; mismatch -> ERROR.
  - DONE: done=1, cpu_hold=0. start -> LEN_HI, with cpu_hold=1 and done=0 from the next cycle.
  - ERROR: err=1, cpu_hold=1. start -> LEN_HI, with err=0 from the next cycle.
- cpu_hold is 0 only in DONE.
- start outside IDLE/DONE/ERROR is ignored.
- When N = 2^ADDR_W, the word counter wraps to 0 after the final write. This is legal and does not raise an error.
- Back-to-back bytes (in_valid held high) are accepted every cycle. Throughput is 1 byte/cycle and there are no bubbles between words.
- in_valid low mid-word stalls with no state change; the partial word is retained indefinitely.
- Reset asserted mid-load forces all reset values immediately. Memory contents already written are left as-is.
- Simultaneous start and in_valid in IDLE: only start acts; no byte is accepted that cycle because in_ready=0.

Decomposition:
- Shared package/include (loader_pkg): state encodings (IDLE, LEN_HI, LEN_LO, DATA, CHECK, DONE, ERROR), BYTES_PER_WORD=4, CHK_INIT=8'h00.
- Sub-module word_assembler:
  - Inputs: clk, rst_n, clr, byte_en, byte_in.
  - Outputs: word_out[31:0], word_valid (one-cycle pulse).
  - Contents: 2-bit byte counter and shift register, honouring BIG_ENDIAN.

Test Plan:
- Load 2 words (bytes 00 02, 20 08 00 05, 00 00 00 08, chk 0x25; BIG_ENDIAN=1) -> imem writes: addr0=0x20080005, addr1=0x00000008; done=1, cpu_hold=0, err=0.
- Same stream with chk 0x24 -> both words still written; err=1, done=0, cpu_hold stays 1.
- N=0 (00 00 then chk 0x00) -> no imem_we; done=1. Repeat with chk 0x01 -> err=1.
- ADDR_W=8, N=0x0101 -> err=1 after LEN_LO; in_ready=0 thereafter; no imem_we.
- Load 1 word with in_valid toggling every other cycle, and rst_n pulsed low after the 2nd data byte -> all outputs at reset values immediately; a subsequent start with a clean stream loads correctly.
- BIG_ENDIAN=0, bytes 05 00 08 20 -> imem_wdata=0x20080005. After DONE, a second start reloads and cpu_hold returns to 1 the cycle after start.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared encodings and constants for the instruction-image loader.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam int         BYTES_PER_WORD = 4;
    localparam logic [1:0] LAST_BYTE      = 2'(BYTES_PER_WORD - 1);
    localparam logic [7:0] CHK_INIT       = 8'h00;

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface instr_loader_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/word_assembler.sv
// Packs four accepted bytes into a 32-bit word; word_valid pulses the cycle after the 4th byte.
module word_assembler
    import loader_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word_out,
    output logic        word_valid
);

    logic [1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 2'd0;
            word_out   <= 32'd0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (clr) begin
                cnt      <= 2'd0;
                word_out <= 32'd0;
            end else if (byte_en) begin
                // Little-endian shifts in from the top so the first byte ends in [7:0].
                word_out   <= BIG_ENDIAN ? {word_out[23:0], byte_in}
                                         : {byte_in, word_out[31:8]};
                cnt        <= cnt + 2'd1;
                word_valid <= (cnt == LAST_BYTE);
            end
        end
    end

endmodule

// File: rtl/instr_loader.sv
// Streams a length-prefixed, XOR-checked program image into imem and releases the CPU when valid.
module instr_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    instr_loader_if.slave  bus,
    output logic           cpu_hold,
    output logic           done,
    output logic           err
);

    // Image may hold exactly 2^ADDR_W words; ADDR_W is expected to be at most 16.
    localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

    state_t            state;
    logic              in_ready;
    logic [7:0]        n_hi;
    logic [7:0]        chk;
    logic [1:0]        byte_cnt;
    logic [15:0]       words_left;
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       word_out;
    logic              word_valid;
    logic              accept;
    logic              launch;
    logic [15:0]       n_full;

    assign accept = bus.in_valid & in_ready;
    assign launch = start & ((state == IDLE) | (state == DONE) | (state == ERROR));
    assign n_full = {n_hi, bus.in_data};

    assign bus.in_ready   = in_ready;
    assign bus.imem_we    = word_valid;
    assign bus.imem_addr  = word_idx;
    assign bus.imem_wdata = word_out;

    word_assembler #(.BIG_ENDIAN(BIG_ENDIAN)) u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (launch),
        .byte_en    (accept & (state == DATA)),
        .byte_in    (bus.in_data),
        .word_out   (word_out),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
            n_hi       <= 8'd0;
            chk        <= CHK_INIT;
            byte_cnt   <= 2'd0;
            words_left <= 16'd0;
            word_idx   <= '0;
        end else begin
            // Wraps to 0 after the last write of a full-capacity image.
            if (word_valid) word_idx <= word_idx + 1'b1;

            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state      <= LEN_HI;
                        in_ready   <= 1'b1;
                        cpu_hold   <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        chk        <= CHK_INIT;
                        byte_cnt   <= 2'd0;
                        words_left <= 16'd0;
                        word_idx   <= '0;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        n_hi  <= bus.in_data;
                        state <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        words_left <= n_full;
                        if ({1'b0, n_full} > CAPACITY) begin
                            state    <= ERROR;
                            in_ready <= 1'b0;
                            err      <= 1'b1;
                        end else if (n_full == 16'd0) begin
                            state <= CHECK;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        chk      <= chk ^ bus.in_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == LAST_BYTE) begin
                            words_left <= words_left - 16'd1;
                            if (words_left == 16'd1) state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (bus.in_data == chk) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            state <= ERROR;
                            err   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench: one big-endian and one little-endian loader fed the same byte stream.
module tb_instr_loader;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic v;
    logic [7:0] d;
    logic hold_be, done_be, err_be;
    logic hold_le, done_le, err_le;
    int total = 0;
    int bad   = 0;

    logic [7:0]  s[$];
    logic [7:0]  be_addr[$];
    logic [31:0] be_data[$];
    logic [7:0]  le_addr[$];
    logic [31:0] le_data[$];

    always #5 clk = ~clk;

    instr_loader_if #(.ADDR_W(8)) bus_be ();
    instr_loader_if #(.ADDR_W(8)) bus_le ();

    assign bus_be.in_valid = v;
    assign bus_be.in_data  = d;
    assign bus_le.in_valid = v;
    assign bus_le.in_data  = d;

    instr_loader #(.ADDR_W(8), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus_be),
        .cpu_hold(hold_be), .done(done_be), .err(err_be)
    );

    instr_loader #(.ADDR_W(8), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .rst_n(rst_n), .start(start), .bus(bus_le),
        .cpu_hold(hold_le), .done(done_le), .err(err_le)
    );

    always @(negedge clk) begin
        if (bus_be.imem_we === 1'b1) begin
            be_addr.push_back(bus_be.imem_addr);
            be_data.push_back(bus_be.imem_wdata);
        end
        if (bus_le.imem_we === 1'b1) begin
            le_addr.push_back(bus_le.imem_addr);
            le_data.push_back(bus_le.imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        be_addr.delete(); be_data.delete();
        le_addr.delete(); le_data.delete();
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        v = 1'b1;
        d = b;
        while (bus_be.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (bus_be.in_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL send_timeout obs=in_ready %b exp=1", bus_be.in_ready);
        end
        @(posedge clk);
        #1 v = 1'b0;
    endtask

    task automatic send_all(input bit gap);
        foreach (s[i]) begin
            send_byte(s[i]);
            if (gap) @(negedge clk);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"}, {31'd0, bus_be.in_ready}, 32'd0);
        check({tag, "_we"},       {31'd0, bus_be.imem_we}, 32'd0);
        check({tag, "_addr"},     {24'd0, bus_be.imem_addr}, 32'd0);
        check({tag, "_wdata"},    bus_be.imem_wdata, 32'd0);
        check({tag, "_hold"},     {31'd0, hold_be}, 32'd1);
        check({tag, "_done"},     {31'd0, done_be}, 32'd0);
        check({tag, "_err"},      {31'd0, err_be}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        v     = 1'b0;
        d     = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;

        // Two-word image, good checksum
        clear_logs();
        pulse_start();
        s = {8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h08, 8'h25};
        send_all(1'b0);
        settle();
        check("t1_nwr", be_data.size(), 32'd2);
        if (be_data.size() == 2) begin
            check("t1_a0", {24'd0, be_addr[0]}, 32'd0);
            check("t1_d0", be_data[0], 32'h2008_0005);
            check("t1_a1", {24'd0, be_addr[1]}, 32'd1);
            check("t1_d1", be_data[1], 32'h0000_0008);
        end
        if (le_data.size() == 2) begin
            check("t1_le_d0", le_data[0], 32'h0500_0820);
            check("t1_le_d1", le_data[1], 32'h0800_0000);
        end else check("t1_le_nwr", le_data.size(), 32'd2);
        check("t1_done", {31'd0, done_be}, 32'd1);
        check("t1_hold", {31'd0, hold_be}, 32'd0);
        check("t1_err",  {31'd0, err_be}, 32'd0);

        // Same image, bad checksum
        clear_logs();
        pulse_start();
        s[10] = 8'h24;
        send_all(1'b0);
        settle();
        check("t2_nwr", be_data.size(), 32'd2);
        if (be_data.size() == 2) check("t2_d1", be_data[1], 32'h0000_0008);
        check("t2_err",  {31'd0, err_be}, 32'd1);
        check("t2_done", {31'd0, done_be}, 32'd0);
        check("t2_hold", {31'd0, hold_be}, 32'd1);

        // Empty image, good then bad checksum
        clear_logs();
        pulse_start();
        s = {8'h00, 8'h00, 8'h00};
        send_all(1'b0);
        settle();
        check("t3_nwr",  be_data.size(), 32'd0);
        check("t3_done", {31'd0, done_be}, 32'd1);
        check("t3_err",  {31'd0, err_be}, 32'd0);
        pulse_start();
        s = {8'h00, 8'h00, 8'h01};
        send_all(1'b0);
        settle();
        check("t3b_err",  {31'd0, err_be}, 32'd1);
        check("t3b_done", {31'd0, done_be}, 32'd0);

        // Length one past capacity
        clear_logs();
        pulse_start();
        s = {8'h01, 8'h01};
        send_all(1'b0);
        check("t4_err",   {31'd0, err_be}, 32'd1);
        check("t4_ready", {31'd0, bus_be.in_ready}, 32'd0);
        settle();
        check("t4_nwr",   be_data.size(), 32'd0);
        check("t4_ready2", {31'd0, bus_be.in_ready}, 32'd0);

        // Full capacity: 256 words of bytes 0..255 repeated, XOR = 0x00
        clear_logs();
        pulse_start();
        s = {8'h01, 8'h00};
        for (int i = 0; i < 1024; i++) s.push_back(8'(i));
        s.push_back(8'h00);
        send_all(1'b0);
        settle();
        check("t4b_nwr", be_data.size(), 32'd256);
        if (be_data.size() == 256) begin
            check("t4b_d0",   be_data[0], 32'h0001_0203);
            check("t4b_a255", {24'd0, be_addr[255]}, 32'd255);
            check("t4b_d255", be_data[255], 32'hFCFD_FEFF);
        end
        check("t4b_done", {31'd0, done_be}, 32'd1);
        check("t4b_err",  {31'd0, err_be}, 32'd0);
        check("t4b_wrap", {24'd0, bus_be.imem_addr}, 32'd0);

        // Stalled load interrupted by reset
        clear_logs();
        pulse_start();
        s = {8'h00, 8'h01, 8'h11};
        send_all(1'b1);
        check("t5_stall_ready", {31'd0, bus_be.in_ready}, 32'd1);
        check("t5_stall_nwr",   be_data.size(), 32'd0);
        send_byte(8'h22);
        @(negedge clk) rst_n = 1'b0;
        #1 check_reset_vals("t5_rst");
        @(negedge clk) rst_n = 1'b1;

        // Start coinciding with a valid byte in IDLE must not consume it
        clear_logs();
        @(negedge clk);
        start = 1'b1; v = 1'b1; d = 8'hFF;
        @(negedge clk);
        start = 1'b0; v = 1'b0;
        s = {8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        send_all(1'b1);
        settle();
        check("t5_nwr", be_data.size(), 32'd1);
        if (be_data.size() == 1) begin
            check("t5_a0", {24'd0, be_addr[0]}, 32'd0);
            check("t5_d0", be_data[0], 32'h1234_5678);
        end
        check("t5_done", {31'd0, done_be}, 32'd1);

        // Reload from DONE; little-endian packing
        clear_logs();
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1;
        check("t6_hold_after_start", {31'd0, hold_be}, 32'd1);
        check("t6_done_after_start", {31'd0, done_be}, 32'd0);
        @(negedge clk) start = 1'b0;
        s = {8'h00, 8'h01, 8'h05, 8'h00, 8'h08, 8'h20, 8'h2D};
        send_all(1'b0);
        settle();
        check("t6_le_nwr", le_data.size(), 32'd1);
        if (le_data.size() == 1) check("t6_le_d0", le_data[0], 32'h2008_0005);
        if (be_data.size() == 1) check("t6_be_d0", be_data[0], 32'h0500_0820);
        check("t6_le_done", {31'd0, done_le}, 32'd1);
        check("t6_le_hold", {31'd0, hold_le}, 32'd0);
        check("t6_le_err",  {31'd0, err_le}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
